// File: rtl/parser_pkg.sv
// rtl/parser_pkg.sv - shared framing constants, TX MAC state type and message byte helpers
package parser_pkg;

  localparam logic [7:0] CHAR_OPEN  = 8'h7B;
  localparam logic [7:0] CHAR_CLOSE = 8'h7D;
  localparam logic [7:0] CHAR_COMMA = 8'h2C;

  localparam logic [4:0] MSG_LEN_SHORT = 5'd6;
  localparam logic [4:0] MSG_LEN_MED   = 5'd11;
  localparam logic [4:0] MSG_LEN_LONG  = 5'd16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_GAP,
    S_DONE
  } tx_state_t;

  function automatic logic [7:0] msg_byte(input logic [127:0] msg, input logic [3:0] idx);
    return msg[{idx, 3'b000} +: 8];
  endfunction

  // Terminator only counts at the fixed short/medium positions; elsewhere it is payload.
  function automatic logic [4:0] msg_len_of(input logic [127:0] msg);
    if (msg_byte(msg, 4'd5) == CHAR_CLOSE)
      return MSG_LEN_SHORT;
    else if (msg_byte(msg, 4'd10) == CHAR_CLOSE)
      return MSG_LEN_MED;
    else
      return MSG_LEN_LONG;
  endfunction

endpackage

// File: rtl/uart_tx_mac.sv
// rtl/uart_tx_mac.sv - validates a 16-byte response message and serializes it bytewise to the UART TX PHY
module uart_tx_mac
  import parser_pkg::*;
#(
  parameter int GAP_CYCLES = 0,
  parameter int GAP_W      = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] msg_data,
  input  logic         msg_valid,
  output logic         msg_ready,
  output logic [7:0]   tx_data,
  output logic         tx_valid,
  input  logic         tx_ready,
  output logic         msg_done,
  output logic         frame_error,
  output logic         busy
);

  localparam logic [GAP_W-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

  tx_state_t        state;
  logic [127:0]     buffer;
  logic [3:0]       byte_idx;
  logic [4:0]       msg_len;
  logic [GAP_W-1:0] gap_cnt;

  logic [4:0] in_len;
  logic       in_ok;
  logic       last_byte;
  logic [3:0] nxt_idx;

  always_comb begin
    in_len    = msg_len_of(msg_data);
    in_ok     = (msg_byte(msg_data, 4'd0) == CHAR_OPEN) &&
                ((in_len != MSG_LEN_LONG) || (msg_byte(msg_data, 4'd15) == CHAR_CLOSE));
    last_byte = ({1'b0, byte_idx} == (msg_len - 5'd1));
    nxt_idx   = byte_idx + 4'd1;
  end

  assign msg_ready = rst_n && (state == S_IDLE);
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      buffer      <= '0;
      byte_idx    <= '0;
      msg_len     <= '0;
      gap_cnt     <= '0;
      tx_data     <= 8'h00;
      tx_valid    <= 1'b0;
      msg_done    <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      msg_done    <= 1'b0;
      frame_error <= 1'b0;
      case (state)
        S_IDLE: begin
          if (msg_valid) begin
            if (in_ok) begin
              buffer   <= msg_data;
              msg_len  <= in_len;
              byte_idx <= '0;
              tx_data  <= msg_data[7:0];
              tx_valid <= 1'b1;
              state    <= S_SEND;
            end else begin
              frame_error <= 1'b1;
            end
          end
        end
        S_SEND: begin
          if (tx_ready) begin
            if (last_byte) begin
              tx_valid <= 1'b0;
              msg_done <= 1'b1;
              state    <= S_DONE;
            end else begin
              byte_idx <= nxt_idx;
              if (GAP_CYCLES == 0) begin
                tx_data <= msg_byte(buffer, nxt_idx);
              end else begin
                tx_valid <= 1'b0;
                gap_cnt  <= GAP_LOAD;
                state    <= S_GAP;
              end
            end
          end
        end
        S_GAP: begin
          if (gap_cnt == '0) begin
            tx_valid <= 1'b1;
            tx_data  <= msg_byte(buffer, byte_idx);
            state    <= S_SEND;
          end else begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end
        S_DONE: begin
          byte_idx <= '0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_mac.sv
// tb/tb_uart_tx_mac.sv - randomized bench for uart_tx_mac with a byte-list reference model
module tb_uart_tx_mac;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [127:0] msg_data    [2];
  logic         msg_valid   [2];
  logic         msg_ready   [2];
  logic [7:0]   tx_data     [2];
  logic         tx_valid    [2];
  logic         tx_ready    [2];
  logic         msg_done    [2];
  logic         frame_error [2];
  logic         busy        [2];

  uart_tx_mac #(.GAP_CYCLES(0), .GAP_W(8)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .msg_data(msg_data[0]), .msg_valid(msg_valid[0]),
    .msg_ready(msg_ready[0]), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
    .tx_ready(tx_ready[0]), .msg_done(msg_done[0]), .frame_error(frame_error[0]), .busy(busy[0])
  );

  uart_tx_mac #(.GAP_CYCLES(3), .GAP_W(8)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .msg_data(msg_data[1]), .msg_valid(msg_valid[1]),
    .msg_ready(msg_ready[1]), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
    .tx_ready(tx_ready[1]), .msg_done(msg_done[1]), .frame_error(frame_error[1]), .busy(busy[1])
  );

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Reference: a frame is a list of bytes; length and validity come from the framing rules.
  function automatic int ref_len(input logic [127:0] m);
    logic [7:0] b [16];
    for (int k = 0; k < 16; k++) b[k] = m[8*k +: 8];
    if (b[0] != 8'h7B) return 0;
    if (b[5] == 8'h7D) return 6;
    if (b[10] == 8'h7D) return 11;
    return (b[15] == 8'h7D) ? 16 : 0;
  endfunction

  function automatic logic [127:0] str2msg(input string s);
    logic [127:0] m = '0;
    for (int k = 0; k < s.len() && k < 16; k++) m[8*k +: 8] = s[k];
    return m;
  endfunction

  int cur = 0;
  int cyc = 0;
  int n_done = 0, n_ferr = 0, n_acc = 0, n_valid = 0;
  int acc_cyc = 0, done_cyc = 0;
  logic [7:0] hs_q[$];
  int hs_cyc[$];
  logic stall_prev = 1'b0;
  logic [7:0] stall_data = 8'h00;

  always begin
    @(negedge clk);
    #2;
    cyc++;
    if (rst_n) begin
      if (stall_prev) check("hold", {23'd0, tx_valid[cur], tx_data[cur]}, {23'd0, 1'b1, stall_data});
      stall_prev = tx_valid[cur] && !tx_ready[cur];
      stall_data = tx_data[cur];
      if (tx_valid[cur] && tx_ready[cur]) begin
        hs_q.push_back(tx_data[cur]);
        hs_cyc.push_back(cyc);
      end
      if (tx_valid[cur]) n_valid++;
      if (msg_done[cur]) begin n_done++; done_cyc = cyc; end
      if (frame_error[cur]) n_ferr++;
      if (msg_valid[cur] && msg_ready[cur]) begin n_acc++; acc_cyc = cyc; end
    end else begin
      stall_prev = 1'b0;
    end
  end

  // rmode: 0 = always ready, 1 = random ready, 2 = five-cycle stall on byte 3 with a busy-time offer
  task automatic run_msg(input logic [127:0] m, input int rmode);
    int len;
    int d0, f0, a0, v0, t, stall_n, bad_sp;
    len = ref_len(m);
    d0 = n_done; f0 = n_ferr; a0 = n_acc; v0 = n_valid;
    stall_n = 0;
    hs_q.delete();
    hs_cyc.delete();
    @(negedge clk);
    tx_ready[cur] = (rmode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
    check("ready_idle", {31'd0, msg_ready[cur]}, 32'd1);
    msg_data[cur] = m;
    msg_valid[cur] = 1'b1;
    @(negedge clk);
    msg_valid[cur] = 1'b0;
    msg_data[cur] = {$urandom, $urandom, $urandom, $urandom};
    for (t = 0; t < 1000 && (len == 0 ? t < 5 : n_done == d0); t++) begin
      case (rmode)
        0: tx_ready[cur] = 1'b1;
        1: tx_ready[cur] = 1'($urandom_range(0, 1));
        default: begin
          if (hs_q.size() == 3 && stall_n < 5 && tx_valid[cur]) begin
            stall_n++;
            tx_ready[cur] = 1'b0;
            msg_valid[cur] = (stall_n == 2);
            msg_data[cur] = str2msg("{R999}");
          end else begin
            tx_ready[cur] = 1'b1;
            msg_valid[cur] = 1'b0;
          end
        end
      endcase
      @(negedge clk);
    end
    msg_valid[cur] = 1'b0;
    if (len > 0) check("done_timeout", {31'd0, n_done > d0}, 32'd1);
    repeat (2) @(negedge clk);
    check("accept_cnt", n_acc - a0, 32'd1);
    check("done_cnt", n_done - d0, (len > 0) ? 32'd1 : 32'd0);
    check("ferr_cnt", n_ferr - f0, (len == 0) ? 32'd1 : 32'd0);
    check("byte_cnt", hs_q.size(), len);
    if (len == 0) check("valid_cycles", n_valid - v0, 32'd0);
    for (int k = 0; k < len && k < hs_q.size(); k++)
      check($sformatf("byte%0d", k), {24'd0, hs_q[k]}, {24'd0, m[8*k +: 8]});
    if (len > 0 && hs_cyc.size() == len) begin
      check("done_lat", done_cyc - hs_cyc[len-1], 32'd1);
      if (rmode == 0) begin
        check("first_lat", hs_cyc[0] - acc_cyc, 32'd1);
        bad_sp = 0;
        for (int k = 1; k < len; k++)
          if (hs_cyc[k] - hs_cyc[k-1] != (cur == 0 ? 1 : 4)) bad_sp++;
        check("spacing", bad_sp, 32'd0);
      end
    end
    if (rmode == 2) check("stall_len", stall_n, 32'd5);
    check("ready_back", {31'd0, msg_ready[cur]}, 32'd1);
  endtask

  function automatic logic [127:0] rand_msg();
    logic [127:0] m = {$urandom, $urandom, $urandom, $urandom};
    int kind = $urandom_range(0, 4);
    m[7:0] = 8'h7B;
    case (kind)
      0: m[47:40] = 8'h7D;
      1: begin m[47:40] = 8'h2C; m[87:80] = 8'h7D; end
      2: begin m[47:40] = 8'h2C; m[87:80] = 8'h2C; m[127:120] = 8'h7D; end
      3: m[7:0] = 8'h41;
      default: begin m[47:40] = 8'h2C; m[87:80] = 8'h2C; m[127:120] = 8'h00; end
    endcase
    return m;
  endfunction

  logic [127:0] tmp;

  initial begin
    for (int i = 0; i < 2; i++) begin
      msg_data[i] = '0;
      msg_valid[i] = 1'b0;
      tx_ready[i] = 1'b1;
    end
    #12;
    for (int i = 0; i < 2; i++) begin
      check("rst_ready", {31'd0, msg_ready[i]}, 32'd0);
      check("rst_txv", {31'd0, tx_valid[i]}, 32'd0);
      check("rst_txd", {24'd0, tx_data[i]}, 32'd0);
      check("rst_busy", {31'd0, busy[i]}, 32'd0);
      check("rst_pulses", {30'd0, msg_done[i], frame_error[i]}, 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    cur = 0;
    run_msg(str2msg("{R010}"), 0);
    run_msg(str2msg("{W001,P0A0,W0B0}"), 0);
    run_msg(str2msg("{W001,P0A0}"), 0);
    tmp = str2msg("{W0}0,P0A0,W0B0}");
    tmp[23:16] = 8'h7D;
    tmp[47:40] = 8'h2C;
    run_msg(tmp, 0);
    tmp = str2msg("{R010}");
    tmp[7:0] = 8'h41;
    run_msg(tmp, 0);
    tmp = str2msg("{W001,P0A0,W0B0}");
    tmp[127:120] = 8'h00;
    run_msg(tmp, 0);
    run_msg(str2msg("{W001,P0A0,W0B0}"), 2);

    cur = 1;
    run_msg(str2msg("{W001,P0A0,W0B0}"), 0);
    run_msg(str2msg("{R010}"), 2);

    for (int n = 0; n < 24; n++) begin
      cur = n % 2;
      run_msg(rand_msg(), 1);
    end

    // Reset while byte 7 is on the wire: everything must abort with no leftovers.
    cur = 1;
    hs_q.delete();
    @(negedge clk);
    msg_data[1] = str2msg("{W001,P0A0,W0B0}");
    msg_valid[1] = 1'b1;
    tx_ready[1] = 1'b1;
    @(negedge clk);
    msg_valid[1] = 1'b0;
    for (int t = 0; t < 200 && !(hs_q.size() == 7 && tx_valid[1]); t++) @(negedge clk);
    check("byte7_reached", hs_q.size(), 32'd7);
    rst_n = 1'b0;
    #1;
    check("abort_txv", {31'd0, tx_valid[1]}, 32'd0);
    check("abort_busy", {31'd0, busy[1]}, 32'd0);
    check("abort_ready", {31'd0, msg_ready[1]}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("post_rst_ready", {31'd0, msg_ready[1]}, 32'd1);
    check("no_residual", hs_q.size(), 32'd7);
    check("post_rst_txv", {31'd0, tx_valid[1]}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_tx_mac.md
Name: uart_tx_MAC

Overview:
Transmit-side MAC, the counterpart of the RX MAC. Accepts a complete 16-byte response message from the parser/responder, validates its framing and determines its length. Serializes the message byte-by-byte to the UART TX PHY over a valid/ready handshake. Uses the same byte layout and terminator rules as the RX side: byte 0 = msg_data[7:0], byte k = msg_data[8k+7:8k].

Parameters:
GAP_CYCLES, 0, idle cycles inserted between consecutive byte handshakes (0 = back-to-back)
GAP_W, 8, width of gap counter; GAP_CYCLES must be < 2**GAP_W

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
msg_data  input  128  message to send, byte 0 in [7:0]
msg_valid  input  1  message offered
msg_ready  output  1  MAC can accept a message (high only in S_IDLE)
tx_data  output  8  byte to PHY
tx_valid  output  1  tx_data valid
tx_ready  input  1  PHY accepts byte this cycle
msg_done  output  1  1-cycle pulse after last byte handshake
frame_error  output  1  1-cycle pulse when an offered message is rejected
busy  output  1  high when not in S_IDLE

Behaviour:
- Reset values: msg_ready=0 during reset, then 1 in S_IDLE; tx_data=0x00, tx_valid=0, msg_done=0, frame_error=0, busy=0; buffer, byte_idx, msg_len and gap counter all cleared. Async reset mid-message aborts it immediately; there is no partial resume.
- Length detect (combinational on msg_data at acceptance):
  - byte5=='}' -> len 6
  - else byte10=='}' -> len 11
  - else len 16
  - '}' at any other position is data (e.g. pixel 125).
- Validity:
  - byte0 must be '{'.
  - For len 16, byte15 must be '}'.
  - Separators and opcodes are not re-checked; the producer owns them.
- FSM states: S_IDLE, S_SEND, S_GAP, S_DONE.
- S_IDLE:
  - msg_ready=1.
  - On msg_valid && valid frame: latch msg_data into buffer, latch msg_len, byte_idx=0 -> S_SEND. tx_valid rises the cycle after acceptance, with tx_data=byte0 (latency 1).
  - On msg_valid && invalid frame: the message is consumed (ready was high) and dropped; frame_error pulses next cycle; stay in S_IDLE.
- S_SEND:
  - tx_valid=1, tx_data=buffer byte[byte_idx].
  - tx_data/tx_valid are held stable until tx_ready.
  - On handshake with byte_idx==msg_len-1 -> S_DONE.
  - Otherwise byte_idx++. If GAP_CYCLES==0, stay in S_SEND, next byte presented the following cycle. Else load counter = GAP_CYCLES-1 -> S_GAP.
- S_GAP: tx_valid=0; count down to 0, then -> S_SEND. This gives exactly GAP_CYCLES idle cycles.
- S_DONE:
  - msg_done=1 for one cycle, tx_valid=0, byte_idx cleared -> S_IDLE.
  - msg_ready stays 0 in this cycle, so minimum spacing is 1 cycle between last handshake and next acceptance.
- msg_valid while busy: ignored (ready low). Input changes during send have no effect (buffer latched).
- byte_idx is 4 bits, never wraps (max 15). msg_len is 5 bits (6/11/16).

Decomposition:
- parser_pkg: reuse CHAR_OPEN, CHAR_CLOSE, CHAR_COMMA.
- Add MSG_LEN_SHORT=6, MSG_LEN_MED=11, MSG_LEN_LONG=16 and TX state enum tx_state_t to parser_pkg, shared with RX-side tests.
- No sub-module: single module; length detect and byte mux are inline.

Test Plan:
- Short msg "{R010}" (7B 52 30 31 30 7D), tx_ready=1, GAP=0 -> 6 consecutive handshakes with those bytes, msg_done 1 cycle after the 6th, msg_ready back high the next cycle.
- Full 16-byte "{W001,P0A0,W0B0}" -> 16 bytes in order, byte15=0x7D last; then a medium 11-byte msg ending '}' at byte10 -> exactly 11 bytes.
- Data byte 0x7D at byte3 with byte5=',' and byte15='}' -> all 16 bytes sent; no early termination.
- Invalid: byte0=0x41 -> frame_error pulse, tx_valid never rises. Len-16 msg with byte15=0x00 -> frame_error, nothing sent.
- Backpressure: tx_ready low 5 cycles while byte 3 is presented -> tx_data stable, tx_valid held; msg_valid pulsed meanwhile is not accepted.
- GAP_CYCLES=3 -> exactly 3 cycles of tx_valid=0 between handshakes. Assert rst_n low mid-byte 7 -> tx_valid=0 immediately; after release msg_ready=1 and no residual bytes are sent.
